// File: rtl/demux8_deser_if.sv
// Byte-side and serial-side signal bundle for the 8-lane serial deserializer.
// The master side drives serial bits and consumer ready; the slave side returns the assembled byte and status.
interface demux8_deser_if;
    logic       d;
    logic       dv;
    logic       sof;
    logic       clr_err;
    logic       qr;
    logic [7:0] q;
    logic       qv;
    logic [2:0] idx;
    logic       ovf;
    logic       ferr;

    modport master (
        output d,
        output dv,
        output sof,
        output clr_err,
        output qr,
        input  q,
        input  qv,
        input  idx,
        input  ovf,
        input  ferr
    );

    modport slave (
        input  d,
        input  dv,
        input  sof,
        input  clr_err,
        input  qr,
        output q,
        output qv,
        output idx,
        output ovf,
        output ferr
    );
endinterface

// File: rtl/demux8_deser.sv
// Serial-to-parallel demux: a 3-bit lane index steers each valid serial bit into a capture
// register; completed bytes move to a one-entry valid/ready holding register.
module demux8_deser #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    demux8_deser_if.slave   bus
);

    logic [2:0] r_idx;
    logic [7:0] r_cap;
    logic [7:0] r_q;
    logic       r_qv;
    logic       r_ovf;
    logic       r_ferr;

    logic [2:0] w_eff_idx;
    logic [2:0] w_lane;
    logic [2:0] w_idx_next;
    logic [7:0] w_cap_merged;
    logic       w_complete;
    logic       w_out_free;
    logic       w_load;
    logic       w_drop;
    logic       w_consume;
    logic       w_sof_err;

    // SOF forces the incoming bit to index 0 regardless of how far the current byte got.
    always_comb begin
        w_eff_idx = r_idx;
        if (bus.sof) begin
            w_eff_idx = 3'd0;
        end else begin
            w_eff_idx = r_idx;
        end
    end

    always_comb begin
        w_lane = w_eff_idx;
        if (MSB_FIRST) begin
            w_lane = 3'd7 - w_eff_idx;
        end else begin
            w_lane = w_eff_idx;
        end
    end

    always_comb begin
        w_cap_merged         = r_cap;
        w_cap_merged[w_lane] = bus.d;
    end

    always_comb begin
        w_idx_next = r_idx;
        if (!bus.dv) begin
            w_idx_next = r_idx;
        end else if (bus.sof) begin
            w_idx_next = 3'd1;
        end else begin
            w_idx_next = r_idx + 3'd1;
        end
    end

    // A slot is free if empty or being drained this very cycle, which gives back-to-back bytes.
    assign w_complete = bus.dv & ~bus.sof & (r_idx == 3'd7);
    assign w_out_free = ~r_qv | bus.qr;
    assign w_load     = w_complete & w_out_free;
    assign w_drop     = w_complete & ~w_out_free;
    assign w_consume  = r_qv & bus.qr;
    assign w_sof_err  = bus.dv & bus.sof & (r_idx != 3'd0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx <= 3'd0;
            r_cap <= 8'h00;
        end else if (bus.dv) begin
            r_idx <= w_idx_next;
            r_cap <= w_cap_merged;
        end else begin
            r_idx <= r_idx;
            r_cap <= r_cap;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q  <= 8'h00;
            r_qv <= 1'b0;
        end else if (w_load) begin
            r_q  <= w_cap_merged;
            r_qv <= 1'b1;
        end else if (w_consume) begin
            r_q  <= r_q;
            r_qv <= 1'b0;
        end else begin
            r_q  <= r_q;
            r_qv <= r_qv;
        end
    end

    // Sticky flags: a new event in the same cycle as the clear keeps the flag set.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ovf  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (bus.clr_err) begin
                r_ovf <= 1'b0;
            end else begin
                r_ovf <= r_ovf;
            end
            if (w_sof_err) begin
                r_ferr <= 1'b1;
            end else if (bus.clr_err) begin
                r_ferr <= 1'b0;
            end else begin
                r_ferr <= r_ferr;
            end
        end
    end

    assign bus.q    = r_q;
    assign bus.qv   = r_qv;
    assign bus.idx  = r_idx;
    assign bus.ovf  = r_ovf;
    assign bus.ferr = r_ferr;

endmodule
